// File: rtl/comparator_sweep_checker.sv
// comparator_sweep_checker
//
// Built-in self-test stage for a WIDTH-bit magnitude comparator. It walks the
// comparator operands through every (A, B) pair, A outer and B inner, both
// unsigned ascending. Once the operands have been stable for SETTLE cycles it
// samples the six comparator flags and checks them against a golden model.
// It reports busy/done/pass, a saturating mismatch count and the first
// failing pair.
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   stIdle   | after reset, waiting for start
//   stSettle | operands driven, counting down SETTLE cycles
//   stCheck  | one cycle: compare flags_in against the golden flags
//   stWait   | pair checked, holding operands until step_en
//   stDone   | sweep complete, results held until start or reset
//
// Ports
//   clk             in   rising-edge clock
//   reset_n         in   synchronous active-low reset
//   start           in   begin a sweep (honoured only in stIdle / stDone)
//   step_en         in   pacing enable, honoured only in stWait
//   flags_in        in   {aGTb, aGEb, aLTb, aLEb, aEQb, aNEb} from the comparator
//   dec_a, dec_b    out  registered comparator operands
//   busy            out  sweep in progress
//   done            out  sweep complete
//   pass            out  valid while done: no mismatches seen
//   err_count       out  mismatching pairs, saturating
//   first_err_a/b   out  operands of the first mismatch
//   first_err_flags out  flags_in observed at the first mismatch

module comparator_sweep_checker #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             step_en,
  input  logic [5:0]       flags_in,
  output logic [WIDTH-1:0] dec_a,
  output logic [WIDTH-1:0] dec_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [5:0]       first_err_flags
);

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(1);
  localparam logic [WIDTH-1:0] OP_MAX      = '1;
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  typedef enum logic [2:0] {
    stIdle,
    stSettle,
    stCheck,
    stWait,
    stDone
  } state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] settleCnt, settleCntNext;
  logic [WIDTH-1:0] decANext, decBNext;
  logic             busyNext, doneNext, passNext;
  logic [ERR_W-1:0] errCountNext;
  logic [WIDTH-1:0] firstErrANext, firstErrBNext;
  logic [5:0]       firstErrFlagsNext;
  logic [5:0]       goldenFlags;
  logic             mismatch;
  logic             lastPair;

  // Flag order matches flags_in: {GT, GE, LT, LE, EQ, NE}.
  always_comb begin
    goldenFlags = {dec_a >  dec_b, dec_a >= dec_b,
                   dec_a <  dec_b, dec_a <= dec_b,
                   dec_a == dec_b, dec_a != dec_b};
  end

  assign mismatch = (flags_in != goldenFlags);
  assign lastPair = (dec_a == OP_MAX) && (dec_b == OP_MAX);

  always_comb begin
    stateNext         = state;
    settleCntNext     = settleCnt;
    decANext          = dec_a;
    decBNext          = dec_b;
    busyNext          = busy;
    doneNext          = done;
    passNext          = pass;
    errCountNext      = err_count;
    firstErrANext     = first_err_a;
    firstErrBNext     = first_err_b;
    firstErrFlagsNext = first_err_flags;

    case (state)
      stIdle, stDone: begin
        if (start) begin
          stateNext         = stSettle;
          settleCntNext     = SETTLE_LOAD;
          decANext          = '0;
          decBNext          = '0;
          busyNext          = 1'b1;
          doneNext          = 1'b0;
          passNext          = 1'b0;
          errCountNext      = '0;
          firstErrANext     = '0;
          firstErrBNext     = '0;
          firstErrFlagsNext = '0;
        end
      end

      stSettle: begin
        if (settleCnt <= CNT_LAST) begin
          stateNext = stCheck;
        end else begin
          settleCntNext = settleCnt - CNT_LAST;
        end
      end

      stCheck: begin
        if (mismatch) begin
          if (err_count != ERR_MAX) begin
            errCountNext = err_count + ERR_W'(1);
          end
          // err_count only ever grows during a sweep, so zero means no
          // earlier mismatch has been captured.
          if (err_count == '0) begin
            firstErrANext     = dec_a;
            firstErrBNext     = dec_b;
            firstErrFlagsNext = flags_in;
          end
        end
        if (lastPair) begin
          stateNext = stDone;
          busyNext  = 1'b0;
          doneNext  = 1'b1;
          passNext  = (errCountNext == '0);
        end else begin
          stateNext = stWait;
        end
      end

      stWait: begin
        if (step_en) begin
          // B is the low half, so its wrap carries into A.
          {decANext, decBNext} = {dec_a, dec_b} + (2 * WIDTH)'(1);
          settleCntNext        = SETTLE_LOAD;
          stateNext            = stSettle;
        end
      end

      default: begin
        stateNext = stIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= stIdle;
      settleCnt       <= '0;
      dec_a           <= '0;
      dec_b           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_flags <= '0;
    end else begin
      state           <= stateNext;
      settleCnt       <= settleCntNext;
      dec_a           <= decANext;
      dec_b           <= decBNext;
      busy            <= busyNext;
      done            <= doneNext;
      pass            <= passNext;
      err_count       <= errCountNext;
      first_err_a     <= firstErrANext;
      first_err_b     <= firstErrBNext;
      first_err_flags <= firstErrFlagsNext;
    end
  end

endmodule

// File: tb/tb_comparator_sweep_checker.sv
module tb_comparator_sweep_checker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       step_en;
  int         faultMode;

  // main instance: default parameters, fault selected by faultMode
  logic [5:0] flagsMain;
  logic [2:0] decA, decB, firstA, firstB;
  logic       busy, done, pass;
  logic [6:0] errCount;
  logic [5:0] firstFlags;

  // saturation instance: ERR_W=5, comparator with aGTb permanently inverted
  logic [5:0] flagsSat;
  logic [2:0] sDecA, sDecB, sFirstA, sFirstB;
  logic       sBusy, sDone, sPass;
  logic [4:0] sErrCount;
  logic [5:0] sFirstFlags;

  typedef struct {
    int         errCount;
    bit         pass;
    int         fa;
    int         fb;
    logic [5:0] ff;
  } res_t;

  res_t qMain[$];
  res_t qSat[$];

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  function automatic logic [5:0] idealFlags(input int a, input int b);
    return {a > b, a >= b, a < b, a <= b, a == b, a != b};
  endfunction

  // mode 0: ideal, 1: aEQb stuck at 0, 2: aGTb inverted
  function automatic logic [5:0] faultyFlags(input int mode, input int a, input int b);
    logic [5:0] f;
    f = idealFlags(a, b);
    if (mode == 1) f = f & 6'b111101;
    else if (mode == 2) f = f ^ 6'b100000;
    return f;
  endfunction

  always_comb begin
    flagsMain = faultyFlags(faultMode, int'(decA), int'(decB));
    flagsSat  = faultyFlags(2, int'(sDecA), int'(sDecB));
  end

  comparator_sweep_checker dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .step_en        (step_en),
    .flags_in       (flagsMain),
    .dec_a          (decA),
    .dec_b          (decB),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (errCount),
    .first_err_a    (firstA),
    .first_err_b    (firstB),
    .first_err_flags(firstFlags)
  );

  comparator_sweep_checker #(.WIDTH(3), .SETTLE(1), .ERR_W(5)) dutSat (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .step_en        (step_en),
    .flags_in       (flagsSat),
    .dec_a          (sDecA),
    .dec_b          (sDecB),
    .busy           (sBusy),
    .done           (sDone),
    .pass           (sPass),
    .err_count      (sErrCount),
    .first_err_a    (sFirstA),
    .first_err_b    (sFirstB),
    .first_err_flags(sFirstFlags)
  );

  // Expected outcome of a full sweep, computed pair by pair in ascending order.
  function automatic res_t sweepModel(input int mode, input int errMax);
    res_t r;
    logic [5:0] obs;
    r.errCount = 0;
    r.pass     = 1'b0;
    r.fa       = 0;
    r.fb       = 0;
    r.ff       = 6'b0;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        obs = faultyFlags(mode, a, b);
        if (obs != idealFlags(a, b)) begin
          if (r.errCount == 0) begin
            r.fa = a;
            r.fb = b;
            r.ff = obs;
          end
          if (r.errCount < errMax) r.errCount++;
        end
      end
    end
    r.pass = (r.errCount == 0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChecks++;
    assert (obs === expv) begin
      nPass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Pulses start for one edge; returns at the falling edge after the start edge.
  task automatic startSweep(input bit expectFull);
    if (expectFull) begin
      qMain.push_back(sweepModel(faultMode, 127));
      qSat.push_back(sweepModel(2, 31));
    end
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int edges);
    edges = 0;
    while (!done && edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic checkDone(input string tag);
    res_t e;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_lastA"}, decA, 3'd7);
    chk({tag, "_lastB"}, decB, 3'd7);
    if (qMain.size() == 0) begin
      chk({tag, "_sbMainEmpty"}, 32'd0, 32'd1);
    end else begin
      e = qMain.pop_front();
      chk({tag, "_err"}, errCount, e.errCount);
      chk({tag, "_pass"}, pass, e.pass);
      chk({tag, "_firstA"}, firstA, e.fa);
      chk({tag, "_firstB"}, firstB, e.fb);
      chk({tag, "_firstFlags"}, firstFlags, e.ff);
    end
    chk({tag, "_satDone"}, sDone, 1'b1);
    if (qSat.size() == 0) begin
      chk({tag, "_sbSatEmpty"}, 32'd0, 32'd1);
    end else begin
      e = qSat.pop_front();
      chk({tag, "_satErr"}, sErrCount, e.errCount);
      chk({tag, "_satPass"}, sPass, e.pass);
      chk({tag, "_satFirstA"}, sFirstA, e.fa);
      chk({tag, "_satFirstB"}, sFirstB, e.fb);
      chk({tag, "_satFirstFlags"}, sFirstFlags, e.ff);
    end
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_decA"}, decA, 3'd0);
    chk({tag, "_decB"}, decB, 3'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_pass"}, pass, 1'b0);
    chk({tag, "_err"}, errCount, 7'd0);
    chk({tag, "_first"}, {firstA, firstB, firstFlags}, 12'd0);
    chk({tag, "_satBusy"}, sBusy, 1'b0);
    chk({tag, "_satErr"}, sErrCount, 5'd0);
    chk({tag, "_satDec"}, {sDecA, sDecB}, 6'd0);
  endtask

  initial begin
    int edges;
    reset_n   = 1'b0;
    start     = 1'b0;
    step_en   = 1'b1;
    faultMode = 0;

    // reset state
    tick(2);
    checkReset("rst");
    reset_n = 1'b1;
    tick(2);
    chk("idle_busy", busy, 1'b0);

    // ideal comparator, full sweep
    startSweep(1'b1);
    chk("t1_busyAfterStart", busy, 1'b1);
    waitDone(edges);
    chk("t1_doneEdge", edges, 191);
    checkDone("t1");

    // aEQb stuck at 0, restart from DONE
    faultMode = 1;
    startSweep(1'b1);
    chk("t2_doneFalls", done, 1'b0);
    chk("t2_busyRises", busy, 1'b1);
    chk("t2_errCleared", errCount, 7'd0);
    waitDone(edges);
    chk("t2_doneEdge", edges, 191);
    checkDone("t2");

    // step_en pacing and B wrap
    faultMode = 0;
    step_en   = 1'b0;
    startSweep(1'b0);
    tick(5);
    chk("t3_holdOps", {decA, decB}, 6'd0);
    chk("t3_holdBusy", busy, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step_en = 1'b1;
      tick(1);
      step_en = 1'b0;
      chk($sformatf("t3_step%0d", k), {decA, decB}, k);
      tick(3);
      chk($sformatf("t3_hold%0d", k), {decA, decB}, k);
    end

    // reset in WAIT, start asserted alongside (reset wins)
    reset_n = 1'b0;
    start   = 1'b1;
    tick(1);
    checkReset("t3rst");
    reset_n = 1'b1;
    start   = 1'b0;
    step_en = 1'b1;
    tick(2);

    // mid-sweep reset at (3,5), start ignored while busy
    startSweep(1'b0);
    edges = 0;
    while (!(decA == 3'd3 && decB == 3'd5) && edges < 300) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = (edges == 10);
    end
    start = 1'b0;
    chk("t4_reach35Edge", edges, 87);
    reset_n = 1'b0;
    start   = 1'b1;
    tick(1);
    checkReset("t4rst");
    reset_n = 1'b1;
    start   = 1'b0;
    tick(3);
    chk("t4_idleBusy", busy, 1'b0);
    chk("t4_idleDec", {decA, decB}, 6'd0);

    // clean sweep after reset
    startSweep(1'b1);
    waitDone(edges);
    chk("t5_doneEdge", edges, 191);
    checkDone("t5");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
